// File: rtl/ipf_pkg.sv
// Shared types and constants for the IPF result-capture buffer.
package ipf_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } ipf_state_e;

  localparam logic MODE_STOP = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  localparam int O_WIDTH_DEF  = 9;
  localparam int LANES_DEF    = 128;
  localparam int RD_LANES_DEF = 8;
  localparam int BEATS        = LANES_DEF / RD_LANES_DEF;

  function automatic int beats_of(input int lanes, input int rd_lanes);
    return lanes / rd_lanes;
  endfunction

endpackage

// File: rtl/ipf_res_ram.sv
// Simple dual-port result memory: one write port, one registered read port.
module ipf_res_ram
  import ipf_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int WIDTH  = LANES_DEF * O_WIDTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Array write and registered read; the read register doubles as the entry register.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ipf_res_buffer.sv
// Result-capture buffer: collects wide IPF result words, then drains them as
// narrow valid/ready beats once the core signals finish.
module ipf_res_buffer
  import ipf_pkg::*;
#(
  parameter int LANES    = LANES_DEF,
  parameter int O_WIDTH  = O_WIDTH_DEF,
  parameter int DEPTH    = 128,
  parameter int RD_LANES = RD_LANES_DEF,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        res_valid,
  input  logic [LANES*O_WIDTH-1:0]    res,
  input  logic                        finish,
  input  logic                        mode,
  input  logic                        clear,
  input  logic                        rd_ready,
  output logic                        rd_valid,
  output logic [RD_LANES*O_WIDTH-1:0] rd_data,
  output logic                        rd_last,
  output logic [ADDR_W:0]             count,
  output logic                        full,
  output logic                        overflow,
  output logic                        drain_done
);

  localparam int RES_W  = LANES * O_WIDTH;
  localparam int RD_W   = RD_LANES * O_WIDTH;
  localparam int NBEATS = beats_of(LANES, RD_LANES);
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO  = (ADDR_W + 1)'(0);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  ipf_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              drain_done_q, drain_done_d;

  logic              ram_we_s;
  logic              ram_re_s;
  logic [RES_W-1:0]  ram_rdata_s;

  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    if (p == ADDR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + ADDR_W'(1);
    end
  endfunction

  ipf_res_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (RES_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (wr_ptr_q),
    .wdata (res),
    .re    (ram_re_s),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata_s)
  );

  // Next-state logic for collection, drain serializer and status flags.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    beat_d       = beat_q;
    rd_valid_d   = rd_valid_q;
    overflow_d   = overflow_q;
    drain_done_d = drain_done_q;
    ram_we_s     = 1'b0;
    ram_re_s     = 1'b0;

    if (clear) begin
      state_d      = ST_COLLECT;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = CNT_ZERO;
      beat_d       = '0;
      rd_valid_d   = 1'b0;
      overflow_d   = 1'b0;
      drain_done_d = 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (res_valid && (count_q != CNT_FULL)) begin
            ram_we_s = 1'b1;
            wr_ptr_d = next_ptr(wr_ptr_q);
            count_d  = count_q + CNT_ONE;
          end else if (res_valid && (mode == MODE_WRAP)) begin
            // Full and wrapping: the write slot is the oldest entry, so the reader skips it.
            ram_we_s   = 1'b1;
            wr_ptr_d   = next_ptr(wr_ptr_q);
            rd_ptr_d   = next_ptr(rd_ptr_q);
            overflow_d = 1'b1;
          end else if (res_valid) begin
            overflow_d = 1'b1;
          end else begin
            ram_we_s = 1'b0;
          end

          if (finish && (count_d == CNT_ZERO)) begin
            state_d      = ST_DONE;
            drain_done_d = 1'b1;
          end else if (finish) begin
            state_d = ST_DRAIN;
            beat_d  = '0;
          end else begin
            state_d = ST_COLLECT;
          end
        end

        ST_DRAIN: begin
          if (res_valid) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end

          if (!rd_valid_q) begin
            ram_re_s   = 1'b1;
            rd_valid_d = 1'b1;
            beat_d     = '0;
          end else if (rd_ready && (beat_q == LAST_BEAT)) begin
            beat_d     = '0;
            rd_valid_d = 1'b0;
            rd_ptr_d   = next_ptr(rd_ptr_q);
            count_d    = count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
              state_d      = ST_DONE;
              drain_done_d = 1'b1;
            end else begin
              state_d = ST_DRAIN;
            end
          end else if (rd_ready) begin
            beat_d = beat_q + BEAT_W'(1);
          end else begin
            beat_d = beat_q;
          end
        end

        ST_DONE: begin
          if (res_valid) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
        end

        default: begin
          state_d = ST_COLLECT;
        end
      endcase
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= CNT_ZERO;
      beat_q       <= '0;
      rd_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      beat_q       <= beat_d;
      rd_valid_q   <= rd_valid_d;
      overflow_q   <= overflow_d;
      drain_done_q <= drain_done_d;
    end
  end

  // Beat selection from the loaded entry; forced to zero when no beat is offered.
  always_comb begin
    rd_data = '0;
    if (rd_valid_q) begin
      rd_data = ram_rdata_s[int'(beat_q) * RD_W +: RD_W];
    end else begin
      rd_data = '0;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_last    = rd_valid_q && (beat_q == LAST_BEAT) && (count_q == CNT_ONE);
  assign count      = count_q;
  assign full       = (count_q == CNT_FULL);
  assign overflow   = overflow_q;
  assign drain_done = drain_done_q;

endmodule

// File: tb/tb_ipf_res_buffer.sv
// Randomized bench for ipf_res_buffer against a queue-based reference model.
module tb_ipf_res_buffer;

  localparam int LANES = 128;
  localparam int O_W   = 9;
  localparam int DEPTH = 128;
  localparam int RDL   = 8;
  localparam int AW    = 7;
  localparam int W     = LANES * O_W;
  localparam int RW    = RDL * O_W;
  localparam int NB    = LANES / RDL;

  logic          clk = 1'b0;
  logic          rst;
  logic          res_valid;
  logic [W-1:0]  res;
  logic          finish;
  logic          mode;
  logic          clear;
  logic          rd_ready;
  logic          rd_valid;
  logic [RW-1:0] rd_data;
  logic          rd_last;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;
  logic          drain_done;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] mq[$];
  bit           m_ovf;
  bit           stopped;

  always #5 clk = ~clk;

  ipf_res_buffer #(
    .LANES(LANES), .O_WIDTH(O_W), .DEPTH(DEPTH), .RD_LANES(RDL), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res(res), .finish(finish),
    .mode(mode), .clear(clear), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_last(rd_last), .count(count), .full(full),
    .overflow(overflow), .drain_done(drain_done)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pat_entry(input int e);
    logic [W-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*O_W +: O_W] = O_W'((e + k) % 512);
    return v;
  endfunction

  function automatic logic [W-1:0] rand_entry();
    logic [W-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*O_W +: O_W] = O_W'($urandom_range(0, 511));
    return v;
  endfunction

  task automatic model_write(input logic [W-1:0] d);
    if (mq.size() < DEPTH) begin
      mq.push_back(d);
    end else begin
      m_ovf = 1'b1;
      if (mode) begin
        mq.delete(0);
        mq.push_back(d);
      end
    end
  endtask

  task automatic wr(input logic [W-1:0] d);
    res_valid = 1'b1;
    res       = d;
    model_write(d);
    cyc();
    res_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    check_eq("clear_count", count, 0);
    check_eq("clear_ovf", overflow, 0);
    check_eq("clear_done", drain_done, 0);
  endtask

  // rmode: 0 always ready, 1 alternating 1,0,1,0, 2 random.
  task automatic drain(input int rmode, input bit wr_en, input logic [W-1:0] wd,
                       input int stop_ent, input int stop_beat, output bit hit);
    int mb, popped, budget, n;
    bit held, rdy;
    logic [RW-1:0] held_d, exp;
    logic [W-1:0] ent;
    hit = 1'b0; mb = 0; popped = 0; held = 1'b0; n = 0;
    if (wr_en) begin
      res_valid = 1'b1;
      res       = wd;
      model_write(wd);
    end
    finish = 1'b1;
    budget = mq.size() * NB * 4 + 50;
    cyc();
    res_valid = 1'b0;
    if (mq.size() == 0) begin
      check_eq("empty_done", drain_done, 1);
      check_eq("empty_valid", rd_valid, 0);
      finish = 1'b0;
      return;
    end
    check_eq("drain_first_bubble", rd_valid, 0);
    while (mq.size() > 0 && budget > 0) begin
      budget--;
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((n % 2) == 0) : ($urandom_range(0, 3) != 0);
      n++;
      if (held) begin
        check_eq("stall_valid", rd_valid, 1);
        check_eq("stall_data", rd_data, held_d);
        held = 1'b0;
      end
      if (rd_valid) begin
        check_eq("drain_count", count, mq.size());
        if (popped == stop_ent && mb == stop_beat) begin
          hit = 1'b1;
          finish = 1'b0;
          return;
        end
        if (rdy) begin
          ent = mq[0];
          exp = ent[mb*RW +: RW];
          check_eq("beat_data", rd_data, exp);
          check_eq("beat_last", rd_last, (mq.size() == 1) && (mb == NB - 1));
          mb++;
          if (mb == NB) begin
            mq.delete(0);
            mb = 0;
            popped++;
          end
        end else begin
          held   = 1'b1;
          held_d = rd_data;
        end
      end
      rd_ready = rdy;
      cyc();
    end
    if (budget == 0) check_eq("drain_timeout", 1, 0);
    rd_ready = 1'b0;
    check_eq("done_flag", drain_done, 1);
    check_eq("done_valid", rd_valid, 0);
    check_eq("done_count", count, 0);
    finish = 1'b0;
  endtask

  initial begin
    rst = 1'b1; res_valid = 1'b0; res = '0; finish = 1'b0;
    mode = 1'b0; clear = 1'b0; rd_ready = 1'b0; m_ovf = 1'b0;
    cyc(); cyc();
    check_eq("rst_valid", rd_valid, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_done", drain_done, 0);
    check_eq("rst_last", rd_last, 0);
    check_eq("rst_data", rd_data, 0);
    rst = 1'b0;
    cyc();

    // Four patterned entries, always ready.
    for (int e = 0; e < 4; e++) wr(pat_entry(e));
    check_eq("t1_count", count, 4);
    drain(0, 1'b0, '0, -1, -1, stopped);
    res_valid = 1'b1; res = rand_entry();
    cyc();
    res_valid = 1'b0; m_ovf = 1'b1;
    check_eq("done_write_ovf", overflow, m_ovf);
    check_eq("done_hold", drain_done, 1);
    do_clear();

    // Stop-on-full with 130 writes.
    mode = 1'b0;
    for (int e = 0; e < 130; e++) begin
      wr(rand_entry());
      if (e == 127) begin
        check_eq("t2_full128", full, 1);
        check_eq("t2_count128", count, 128);
        check_eq("t2_ovf128", overflow, 0);
      end
    end
    check_eq("t2_count", count, mq.size());
    check_eq("t2_ovf", overflow, m_ovf);
    drain(2, 1'b0, '0, -1, -1, stopped);
    do_clear();

    // Wrap mode with 131 writes.
    mode = 1'b1;
    for (int e = 0; e < 131; e++) wr(pat_entry(e));
    check_eq("t3_count", count, 128);
    check_eq("t3_full", full, 1);
    check_eq("t3_ovf", overflow, m_ovf);
    drain(2, 1'b0, '0, -1, -1, stopped);
    do_clear();

    // Alternating ready.
    mode = 1'b0;
    for (int e = 0; e < 5; e++) wr(rand_entry());
    drain(1, 1'b0, '0, -1, -1, stopped);
    do_clear();

    // Finish on an empty buffer.
    drain(0, 1'b0, '0, -1, -1, stopped);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_eq("empty_stay_low", rd_valid, 0);
    end
    do_clear();

    // Write and finish in the same cycle.
    drain(2, 1'b1, rand_entry(), -1, -1, stopped);
    do_clear();

    // Asynchronous reset mid-drain, then a fresh collect.
    for (int e = 0; e < 4; e++) wr(rand_entry());
    drain(0, 1'b0, '0, 2, 5, stopped);
    check_eq("t7_reached", stopped, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", rd_valid, 0);
    check_eq("arst_count", count, 0);
    check_eq("arst_done", drain_done, 0);
    check_eq("arst_data", rd_data, 0);
    mq.delete(); m_ovf = 1'b0; rd_ready = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    wr(rand_entry());
    drain(0, 1'b0, '0, -1, -1, stopped);
    check_eq("t7_ovf", overflow, m_ovf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
